// File: rtl/vc_credit_tx.sv
// Credit-based link transmitter: per-VC credit counters, round-robin grant among
// VCs with a pending flit and a free downstream slot, and a registered link stage.
module vc_credit_tx #(
  parameter int NUM_VC     = 2,
  parameter int VC_ID_BITS = 1,
  parameter int FLIT_BITS  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_WIDTH  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VC-1:0]              req_valid,
  input  logic [NUM_VC*FLIT_BITS-1:0]    req_flit,
  output logic [NUM_VC-1:0]              req_ready,
  output logic                           tx_valid,
  output logic [VC_ID_BITS-1:0]          tx_vc,
  output logic [FLIT_BITS-1:0]           tx_flit,
  input  logic                           credit_valid,
  input  logic [VC_ID_BITS-1:0]          credit_vc,
  output logic [NUM_VC*CTR_WIDTH-1:0]    credit_count,
  output logic                           credit_err
);

  localparam logic [CTR_WIDTH-1:0] CREDIT_MAX = CTR_WIDTH'(FIFO_DEPTH);

  logic [CTR_WIDTH-1:0]  r_credit [NUM_VC];
  logic [VC_ID_BITS-1:0] r_ptr;
  logic                  r_tx_valid;
  logic [VC_ID_BITS-1:0] r_tx_vc;
  logic [FLIT_BITS-1:0]  r_tx_flit;
  logic                  r_err;

  logic [NUM_VC-1:0]     w_elig;
  logic [NUM_VC-1:0]     w_ret;
  logic [NUM_VC-1:0]     w_grant;
  logic [VC_ID_BITS-1:0] w_idx;
  logic [VC_ID_BITS-1:0] w_winner;
  logic                  w_found;
  logic                  w_grant_any;
  logic [FLIT_BITS-1:0]  w_sel_flit;
  logic                  w_ovf;

  // Eligibility and credit-return decode per VC; only registered credits count
  always_comb begin
    w_elig = '0;
    w_ret  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_elig[v] = req_valid[v] && (r_credit[v] != '0);
      w_ret[v]  = credit_valid && (credit_vc == VC_ID_BITS'(v));
    end
  end

  // Round-robin search upward from the pointer; index wraps naturally at NUM_VC
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      w_idx = r_ptr + VC_ID_BITS'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
    w_grant_any = w_found && !rst;
    w_grant     = '0;
    if (w_grant_any) begin
      w_grant[w_winner] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  // Winner payload mux and overflow detect
  always_comb begin
    w_sel_flit = '0;
    w_ovf      = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_winner == VC_ID_BITS'(v)) begin
        w_sel_flit = req_flit[v*FLIT_BITS +: FLIT_BITS];
      end else begin
        w_sel_flit = w_sel_flit;
      end
      if (w_ret[v] && !w_grant[v] && (r_credit[v] == CREDIT_MAX)) begin
        w_ovf = 1'b1;
      end else begin
        w_ovf = w_ovf;
      end
    end
  end

  // Credit counters: a grant and a return in the same cycle cancel out
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (rst) begin
        r_credit[v] <= CREDIT_MAX;
      end else if (w_grant[v] && !w_ret[v]) begin
        r_credit[v] <= r_credit[v] - CTR_WIDTH'(1);
      end else if (w_ret[v] && !w_grant[v] && (r_credit[v] != CREDIT_MAX)) begin
        r_credit[v] <= r_credit[v] + CTR_WIDTH'(1);
      end else begin
        r_credit[v] <= r_credit[v];
      end
    end
  end

  // Pointer, sticky overflow flag and link register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_vc    <= '0;
      r_tx_flit  <= '0;
    end else begin
      r_err      <= r_err | w_ovf;
      r_tx_valid <= w_grant_any;
      if (w_grant_any) begin
        r_ptr     <= w_winner + VC_ID_BITS'(1);
        r_tx_vc   <= w_winner;
        r_tx_flit <= w_sel_flit;
      end else begin
        r_ptr     <= r_ptr;
        r_tx_vc   <= r_tx_vc;
        r_tx_flit <= r_tx_flit;
      end
    end
  end

  // Output packing
  always_comb begin
    credit_count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_count[v*CTR_WIDTH +: CTR_WIDTH] = r_credit[v];
    end
  end

  assign req_ready  = w_grant;
  assign tx_valid   = r_tx_valid;
  assign tx_vc      = r_tx_vc;
  assign tx_flit    = r_tx_flit;
  assign credit_err = r_err;

endmodule
